// File: rtl/bp_be_branch_resolver.sv
// Branch resolver: computes actual next PC / mispredict and queues results for the FE.
// Latency: an accepted result reaches the head one cycle later; drops wrong-path results after a miss.
// Backpressure: br_ready_o = ~full from registered state only; FE pops with valid/yumi.

// Generic circular FIFO; any depth >= 2, count-based full/empty, synchronous clear.
// Latency: one cycle from enqueue to visibility at the head.
// Backpressure: full_o from registered count; yumi ignored while empty.
module bp_be_resolve_fifo #(
    parameter int width_p = 8,
    parameter int els_p   = 4
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               clr_i,
    input  logic               enq_v_i,
    input  logic [width_p-1:0] enq_dat_i,
    output logic               full_o,
    input  logic               deq_yumi_i,
    output logic               deq_v_o,
    output logic [width_p-1:0] deq_dat_o
);
    localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int cnt_w = $clog2(els_p + 1);

    logic [width_p-1:0] mem [els_p];
    logic [ptr_w-1:0]   wptr_q, rptr_q;
    logic [cnt_w-1:0]   cnt_q;
    logic               enq, deq;

    function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
        return (p == ptr_w'(els_p - 1)) ? '0 : p + ptr_w'(1);
    endfunction

    assign full_o    = (cnt_q == cnt_w'(els_p));
    assign deq_v_o   = (cnt_q != '0);
    assign deq_dat_o = mem[rptr_q];
    assign enq       = enq_v_i & ~full_o & ~clr_i;
    assign deq       = deq_yumi_i & deq_v_o & ~clr_i;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else if (clr_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (enq) wptr_q <= ptr_inc(wptr_q);
            if (deq) rptr_q <= ptr_inc(rptr_q);
            if (enq && !deq)      cnt_q <= cnt_q + cnt_w'(1);
            else if (deq && !enq) cnt_q <= cnt_q - cnt_w'(1);
        end
    end

    // Payload storage needs no reset; validity is tracked by cnt_q.
    always_ff @(posedge clk_i) begin
        if (enq) mem[wptr_q] <= enq_dat_i;
    end
endmodule

module bp_be_branch_resolver #(
    parameter int vaddr_width_p               = 39,
    parameter int branch_metadata_fwd_width_p = 36,
    parameter int fifo_els_p                  = 4,
    parameter int squash_cnt_width_p          = 8
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    input  logic                                   flush_i,
    input  logic                                   br_v_i,
    output logic                                   br_ready_o,
    input  logic [vaddr_width_p-1:0]               br_pc_i,
    input  logic [vaddr_width_p-1:0]               br_tgt_i,
    input  logic                                   br_taken_i,
    input  logic                                   br_nonbr_i,
    input  logic [vaddr_width_p-1:0]               br_pred_npc_i,
    input  logic [branch_metadata_fwd_width_p-1:0] br_metadata_i,
    output logic                                   resolve_v_o,
    output logic [vaddr_width_p-1:0]               resolve_pc_o,
    output logic                                   resolve_miss_o,
    output logic                                   resolve_taken_o,
    output logic                                   resolve_nonbr_o,
    output logic [branch_metadata_fwd_width_p-1:0] resolve_br_metadata_o,
    input  logic                                   resolve_yumi_i,
    output logic [squash_cnt_width_p-1:0]          squash_cnt_o
);
    typedef struct packed {
        logic [vaddr_width_p-1:0]               npc;
        logic                                   miss;
        logic                                   taken;
        logic                                   nonbr;
        logic [branch_metadata_fwd_width_p-1:0] metadata;
    } entry_t;

    typedef enum logic {e_run, e_drop} state_e;

    state_e state_q, state_n;
    entry_t in_entry, head;
    logic   full, empty_n, accept, enq, drop, deq;

    always_comb begin
        in_entry          = '0;
        in_entry.taken    = br_taken_i & ~br_nonbr_i;
        in_entry.nonbr    = br_nonbr_i;
        in_entry.npc      = in_entry.taken ? br_tgt_i : br_pc_i + vaddr_width_p'(4);
        in_entry.miss     = (in_entry.npc != br_pred_npc_i);
        in_entry.metadata = br_metadata_i;
    end

    assign br_ready_o = ~full;
    assign accept     = br_v_i & br_ready_o & ~flush_i;
    assign enq        = accept & (state_q == e_run);
    assign drop       = accept & (state_q == e_drop);
    assign deq        = resolve_yumi_i & resolve_v_o & ~flush_i;

    bp_be_resolve_fifo #(
        .width_p ($bits(entry_t)),
        .els_p   (fifo_els_p)
    ) fifo (
        .clk_i      (clk_i),
        .reset_n_i  (reset_n_i),
        .clr_i      (flush_i),
        .enq_v_i    (enq),
        .enq_dat_i  (in_entry),
        .full_o     (full),
        .deq_yumi_i (deq),
        .deq_v_o    (empty_n),
        .deq_dat_o  (head)
    );

    // Flags are gated by valid so reset forces them low without resetting storage.
    assign resolve_v_o           = empty_n;
    assign resolve_pc_o          = head.npc;
    assign resolve_miss_o        = empty_n & head.miss;
    assign resolve_taken_o       = empty_n & head.taken;
    assign resolve_nonbr_o       = empty_n & head.nonbr;
    assign resolve_br_metadata_o = head.metadata;

    always_comb begin
        state_n = state_q;
        if (flush_i)                                   state_n = e_run;
        else if (state_q == e_run && enq && in_entry.miss) state_n = e_drop;
        else if (state_q == e_drop && deq && head.miss)    state_n = e_run;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= e_run;
            squash_cnt_o <= '0;
        end else begin
            state_q <= state_n;
            if (drop && squash_cnt_o != '1)
                squash_cnt_o <= squash_cnt_o + squash_cnt_width_p'(1);
        end
    end
endmodule

// File: tb/tb_bp_be_branch_resolver.sv
// Directed bench for bp_be_branch_resolver: depth-4 instance for function, depth-3 for pointer wrap.
module tb_bp_be_branch_resolver;
    logic        clk = 1'b0;
    logic        reset_n, flush, br_v, br_taken, br_nonbr, yumi;
    logic [38:0] br_pc, br_tgt, br_pred;
    logic [35:0] br_md;

    logic        ready4, v4, miss4, taken4, nonbr4;
    logic [38:0] pc4;
    logic [35:0] md4;
    logic [7:0]  sq4;
    logic        ready3, v3, miss3, taken3, nonbr3;
    logic [38:0] pc3;
    logic [35:0] md3;
    logic [7:0]  sq3;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bp_be_branch_resolver #(.fifo_els_p(4)) dut4 (
        .clk_i(clk), .reset_n_i(reset_n), .flush_i(flush),
        .br_v_i(br_v), .br_ready_o(ready4), .br_pc_i(br_pc), .br_tgt_i(br_tgt),
        .br_taken_i(br_taken), .br_nonbr_i(br_nonbr), .br_pred_npc_i(br_pred),
        .br_metadata_i(br_md), .resolve_v_o(v4), .resolve_pc_o(pc4),
        .resolve_miss_o(miss4), .resolve_taken_o(taken4), .resolve_nonbr_o(nonbr4),
        .resolve_br_metadata_o(md4), .resolve_yumi_i(yumi), .squash_cnt_o(sq4)
    );

    bp_be_branch_resolver #(.fifo_els_p(3)) dut3 (
        .clk_i(clk), .reset_n_i(reset_n), .flush_i(flush),
        .br_v_i(br_v), .br_ready_o(ready3), .br_pc_i(br_pc), .br_tgt_i(br_tgt),
        .br_taken_i(br_taken), .br_nonbr_i(br_nonbr), .br_pred_npc_i(br_pred),
        .br_metadata_i(br_md), .resolve_v_o(v3), .resolve_pc_o(pc3),
        .resolve_miss_o(miss3), .resolve_taken_o(taken3), .resolve_nonbr_o(nonbr3),
        .resolve_br_metadata_o(md3), .resolve_yumi_i(yumi), .squash_cnt_o(sq3)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [38:0] pc, input logic [38:0] tgt, input logic [38:0] pred,
                       input logic tk, input logic nb, input logic [35:0] md);
        br_v     = 1'b1;
        br_pc    = pc;
        br_tgt   = tgt;
        br_pred  = pred;
        br_taken = tk;
        br_nonbr = nb;
        br_md    = md;
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0; br_v = 1'b0; br_taken = 1'b0; br_nonbr = 1'b0;
        yumi = 1'b0; br_pc = '0; br_tgt = '0; br_pred = '0; br_md = '0;
        #3;
        chk("rst_v", v4, 0);
        chk("rst_miss", miss4, 0);
        chk("rst_sq", sq4, 0);
        tick();
        reset_n = 1'b1;
        #1;
        chk("rst_ready", ready4, 1);

        // Attaboy
        put(39'h1000, 39'h1040, 39'h1040, 1, 0, 36'h11);
        chk("atta_lat", v4, 0);
        tick();
        br_v = 1'b0;
        chk("atta_v", v4, 1);
        chk("atta_pc", pc4, 39'h1040);
        chk("atta_miss", miss4, 0);
        chk("atta_taken", taken4, 1);
        chk("atta_md", md4, 36'h11);
        yumi = 1'b1; tick(); yumi = 1'b0;
        chk("atta_empty", v4, 0);

        // Not-taken mispredict, then three wrong-path drops
        put(39'h2000, 39'h0, 39'h2080, 0, 0, 36'h22);
        tick();
        chk("mis_pc", pc4, 39'h2004);
        chk("mis_miss", miss4, 1);
        put(39'h2100, 39'h0, 39'h2104, 0, 0, 36'h23);
        repeat (3) tick();
        br_v = 1'b0;
        chk("mis_sq3", sq4, 3);
        chk("mis_only_head", pc4, 39'h2004);
        put(39'h2200, 39'h0, 39'h2204, 0, 0, 36'h24);
        yumi = 1'b1;
        tick();
        yumi = 1'b0; br_v = 1'b0;
        chk("mis_deq_drop_v", v4, 0);
        chk("mis_deq_drop_sq", sq4, 4);
        put(39'h2300, 39'h0, 39'h2304, 0, 0, 36'h25);
        tick();
        br_v = 1'b0;
        chk("mis_resume_v", v4, 1);
        chk("mis_resume_pc", pc4, 39'h2304);
        yumi = 1'b1; tick(); yumi = 1'b0;

        // Non-branch predicted taken from BTB
        put(39'h3000, 39'h3100, 39'h3100, 1, 1, 36'h33);
        tick();
        br_v = 1'b0;
        chk("nb_pc", pc4, 39'h3004);
        chk("nb_nonbr", nonbr4, 1);
        chk("nb_taken", taken4, 0);
        chk("nb_miss", miss4, 1);
        yumi = 1'b1; tick(); yumi = 1'b0;

        // Full / backpressure
        for (int i = 0; i < 4; i++) begin
            put(39'h4000 + 39'(16 * i), 39'h0, 39'h4004 + 39'(16 * i), 0, 0, 36'(i + 1));
            chk("full_rdy_fill", ready4, 1);
            tick();
        end
        put(39'h4040, 39'h0, 39'h4044, 0, 0, 36'd5);
        chk("full_rdy0", ready4, 0);
        tick();
        chk("full_held_rdy", ready4, 0);
        chk("full_head1", md4, 1);
        yumi = 1'b1; tick(); yumi = 1'b0;
        chk("full_rdy1", ready4, 1);
        tick();
        br_v = 1'b0;
        for (int i = 2; i <= 5; i++) begin
            chk("full_order", md4, 64'(i));
            if (i == 5) chk("full_pc5", pc4, 39'h4044);
            yumi = 1'b1; tick(); yumi = 1'b0;
        end
        chk("full_drained", v4, 0);

        // Flush with queued entries in drop state
        put(39'h5000, 39'h0, 39'h5004, 0, 0, 36'h51); tick();
        put(39'h5010, 39'h0, 39'h0, 0, 0, 36'h52); tick();
        put(39'h5100, 39'h0, 39'h0, 0, 0, 36'h53);
        flush = 1'b1; yumi = 1'b1;
        tick();
        flush = 1'b0; yumi = 1'b0; br_v = 1'b0;
        chk("fl_v", v4, 0);
        chk("fl_sq", sq4, 4);
        yumi = 1'b1; tick(); yumi = 1'b0;
        chk("spur_v", v4, 0);
        chk("spur_rdy", ready4, 1);
        put(39'h5200, 39'h0, 39'h5204, 0, 0, 36'h54); tick(); br_v = 1'b0;
        chk("fl_run_v", v4, 1);
        chk("fl_run_pc", pc4, 39'h5204);
        chk("fl_run_sq", sq4, 4);
        yumi = 1'b1; tick(); yumi = 1'b0;

        // Async reset while draining in drop state
        put(39'h7000, 39'h0, 39'h7004, 0, 0, 36'h71); tick();
        put(39'h7010, 39'h0, 39'h7014, 0, 0, 36'h72); tick();
        put(39'h7020, 39'h0, 39'h0, 0, 0, 36'h73); tick();
        tick();
        br_v = 1'b0;
        chk("ar_pre_sq", sq4, 5);
        chk("ar_pre_v", v4, 1);
        #3;
        reset_n = 1'b0;
        #1;
        chk("ar_v", v4, 0);
        chk("ar_sq", sq4, 0);
        chk("ar_taken", taken4, 0);
        #1;
        reset_n = 1'b1;
        tick();
        put(39'h7100, 39'h0, 39'h7104, 0, 0, 36'h74); tick(); br_v = 1'b0;
        chk("ar_run_v", v4, 1);
        chk("ar_run_pc", pc4, 39'h7104);
        chk("ar_run_miss", miss4, 0);
        yumi = 1'b1; tick(); yumi = 1'b0;

        // Squash counter saturation
        put(39'h6000, 39'h0, 39'h0, 0, 0, 36'h61); tick();
        repeat (260) tick();
        br_v = 1'b0;
        chk("sat_sq", sq4, 8'hFF);
        yumi = 1'b1; tick(); yumi = 1'b0;
        chk("sat_empty", v4, 0);
        chk("sat_hold", sq4, 8'hFF);

        // Pointer wrap on the depth-3 instance
        reset_n = 1'b0; #2; reset_n = 1'b1;
        tick();
        for (int i = 1; i <= 3; i++) begin
            put(39'h8000 + 39'(16 * i), 39'h0, 39'h8004 + 39'(16 * i), 0, 0, 36'(i)); tick();
        end
        br_v = 1'b0;
        chk("w3_full", ready3, 0);
        for (int k = 0; k < 7; k++) begin
            chk("w3_order", md3, 64'(k + 1));
            yumi = 1'b1; tick(); yumi = 1'b0;
            put(39'h8000 + 39'(16 * (k + 4)), 39'h0, 39'h8004 + 39'(16 * (k + 4)), 0, 0, 36'(k + 4));
            tick();
            br_v = 1'b0;
        end
        for (int k = 8; k <= 10; k++) begin
            chk("w3_drain", md3, 64'(k));
            if (k == 10) chk("w3_pc10", pc3, 39'h80A4);
            yumi = 1'b1; tick(); yumi = 1'b0;
        end
        chk("w3_empty", v3, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/bp_be_branch_resolver.md
Name: bp_be_branch_resolver

Overview:
- Backend-side producer of branch resolutions for the frontend PC generator.
- Takes resolved control-flow results from the execute pipe and computes the actual next PC and the mispredict flag.
- Buffers results in a small circular FIFO and presents them on the FE resolve interface (valid/yumi).
- After a mispredict, drops wrong-path results until the FE has consumed the redirect.

Parameters:
vaddr_width_p, 39, virtual address width
branch_metadata_fwd_width_p, 36, width of opaque FE branch metadata forwarded with each instruction
fifo_els_p, 4, resolution FIFO depth; any value >= 2, need not be a power of two
squash_cnt_width_p, 8, width of saturating wrong-path drop counter

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
flush_i  in  1  BE pipeline flush (exception/interrupt); clears all state
br_v_i  in  1  execute-stage control-flow result valid
br_ready_o  out  1  resolver can accept br_v_i this cycle
br_pc_i  in  vaddr_width_p  PC of resolved instruction
br_tgt_i  in  vaddr_width_p  computed target (branch/jal/jalr)
br_taken_i  in  1  instruction redirected control flow
br_nonbr_i  in  1  instruction is not control-flow (FE predicted it from BTB)
br_pred_npc_i  in  vaddr_width_p  next PC the FE fetched after this instruction
br_metadata_i  in  branch_metadata_fwd_width_p  FE metadata for this instruction
resolve_v_o  out  1  head entry valid
resolve_pc_o  out  vaddr_width_p  actual next PC of head entry
resolve_miss_o  out  1  head entry mispredicted
resolve_taken_o  out  1  head entry taken
resolve_nonbr_o  out  1  head entry non-branch
resolve_br_metadata_o  out  branch_metadata_fwd_width_p  head metadata, unmodified
resolve_yumi_i  in  1  FE consumed head (ignored when resolve_v_o=0)
squash_cnt_o  out  squash_cnt_width_p  saturating count of dropped wrong-path results

Behaviour:
- Reset (reset_n_i=0, any time, asynchronous): FIFO empty, pointers 0, state e_run, squash_cnt_o=0. Forces resolve_v_o=0 and resolve_miss_o/taken/nonbr=0; resolve_pc_o/metadata don't-care. br_ready_o=1 once reset deasserts.
- Next-PC arithmetic, modulo 2^vaddr_width_p:
  - npc = (br_taken_i & ~br_nonbr_i) ? br_tgt_i : br_pc_i + 4
  - taken is forced 0 when br_nonbr_i=1
  - miss = (npc != br_pred_npc_i)
- Stored fields per entry: npc, miss, taken, nonbr, metadata.
- br_ready_o = ~full (registered state only; no combinational path from resolve_yumi_i).
- Enqueue occurs when br_v_i & br_ready_o & state==e_run & ~flush_i.
- Dequeue occurs when resolve_yumi_i & resolve_v_o.
- resolve_v_o = ~empty. Outputs are driven from head storage.
- Latency: result accepted in cycle t is visible at the head no earlier than cycle t+1.
- Ordering: strict FIFO. Attaboys older than a miss drain before it.
- Simultaneous enqueue and dequeue: allowed when not full; occupancy unchanged.
- Pointers wrap from fifo_els_p-1 to 0.
- States:
  - e_run: normal operation. Enqueueing an entry with miss=1 moves to e_drop next cycle.
  - e_drop: br_ready_o still follows ~full. Accepted inputs (br_v_i & br_ready_o) are discarded, not enqueued, and increment squash_cnt_o, saturating at all-ones.
  - e_drop -> e_run on the cycle after the miss entry is dequeued; the FIFO holds at most one miss. An input in that same dequeue cycle is still dropped.
- flush_i: next cycle the FIFO is empty and state is e_run.
  - flush_i beats enqueue and dequeue in the same cycle; the input is neither enqueued nor counted.
  - squash_cnt_o is not cleared by flush_i.
- resolve_yumi_i with resolve_v_o=0 has no effect. This is a required case: the FE may assert yumi speculatively.

Test Plan:
- Attaboy: pc=0x1000, taken=1, tgt=0x1040, pred_npc=0x1040 -> next cycle resolve_v_o=1, pc=0x1040, miss=0, taken=1; yumi -> empty.
- Mispredict not-taken: pc=0x2000, taken=0, pred_npc=0x2080 -> resolve_pc_o=0x2004, miss=1. Three further br_v_i are dropped (squash_cnt_o=3) until yumi on the miss. The next input after that is enqueued.
- Nonbr: pc=0x3000, nonbr=1, taken=1, tgt=0x3100, pred_npc=0x3100 -> pc=0x3004, nonbr=1, taken=0, miss=1.
- Full/backpressure, fifo_els_p=4: four attaboys with yumi low -> br_ready_o=0.
  - Fifth br_v_i held until one yumi; order 1..5 preserved.
  - Also run with fifo_els_p=3 to check pointer wrap.
- Flush and spurious yumi: two entries queued, flush_i=1 with simultaneous br_v_i -> next cycle resolve_v_o=0, squash_cnt_o unchanged; yumi with v=0 leaves state unchanged.
- Async reset mid-drain: reset_n_i pulled low between clock edges with 3 entries and state e_drop -> resolve_v_o=0 immediately, squash_cnt_o=0, e_run after release. Also check 0xFF saturation with squash_cnt_width_p=8.
